ac3_acc_bank: RTL and testbench
===============================

# ac3_acc_bank

Parametrised accumulator bank for the AC3 stage. It replaces the fixed 4:1 write-select path with NCH channel registers that can be loaded or accumulated from AC2 results under a valid/ready handshake. A drain sequencer streams every channel out in order, clearing each one as it goes. It sits between the AC2 outputs and the AC3 output interface.

## Interface
- M, 16, register dimension (width term $clog2(M))
- Pa, 8, activation precision
- Pw, 8, weight precision
- MNO, 288, maximum number of operands (width term $clog2(MNO))
- NCH, 4, channel count (≥2; power of two not required)
- W (localparam), $clog2(M)+Pa+Pw+$clog2(MNO), data width (29 with defaults)
- CW (localparam), $clog2(NCH), channel index width

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  AC2 word present
- in_ready  out  1  bank accepts the word
- in_data  in  W  AC2 result
- in_sel  in  CW  target channel
- in_acc  in  1  1 = accumulate, 0 = load (overwrite)
- drain  in  1  one-cycle pulse requesting readout
- busy  out  1  drain in progress
- out_valid  out  1  out_data/out_ch/out_sat valid
- out_ready  in  1  consumer accepts
- out_data  out  W  channel value
- out_ch  out  CW  channel index of out_data
- out_sat  out  1  channel saturated since last clear

## Operation
- State machine: IDLE, DRAIN, LAST.
- IDLE: in_ready=1. A transfer (in_valid & in_ready) with in_sel<NCH updates acc[in_sel]:
  - in_acc=0: acc[in_sel] = in_data; sat[in_sel] cleared.
  - in_acc=1: unsigned W+1-bit sum. On carry, acc[in_sel] = all-ones and sat[in_sel] is set (sticky).
- in_sel ≥ NCH: the word is accepted and dropped. No register changes.
- drain in IDLE: go to DRAIN with rd_ptr=0. A transfer in the same cycle is applied first and is visible in the drain.
- DRAIN: in_ready=0. Present acc[rd_ptr], sat[rd_ptr] and rd_ptr on the outputs. On out_valid & out_ready:
  - clear acc[rd_ptr] and sat[rd_ptr];
  - increment rd_ptr;
  - when the pointer reaches NCH-1, go to LAST.
- LAST: present channel NCH-1. On handshake, clear it and return to IDLE.
- drain pulses while busy are ignored.
- Reset mid-drain: all state returns to reset values immediately. The partial drain is discarded.

## Timing
- Reset values: acc=0, sat=0, state=IDLE, rd_ptr=0, in_ready=1, busy=0, out_valid=0, out_data=0, out_ch=0, out_sat=0.
- in_ready is a registered function of state. It is low from the cycle after drain is sampled until the cycle after the final handshake.
- Accumulate latency: a transfer at edge k updates acc at edge k. Back-to-back accumulates to the same channel every cycle are supported without bubbles.
- Output latency: out_valid rises one cycle after drain is sampled. Outputs are registered.
- Output handshake: out_data, out_ch and out_sat stay stable while out_valid & !out_ready. After a handshake, the next channel is valid the following cycle, giving one word per cycle with out_ready held high.
- busy = (state != IDLE). It falls in the cycle after the last handshake, and in_ready rises in the same cycle.
- A full drain with out_ready held high takes NCH+1 cycles from the drain pulse to in_ready=1.

## Structure
- Package ac3_pkg:
  - typedef enum state_t {IDLE, DRAIN, LAST};
  - function ac3_width(M,Pa,Pw,MNO) returning W, shared with the AC2/AC3 blocks.
- Sub-module ac3_sat_add:
  - combinational W-bit saturating adder;
  - outputs sum and overflow.
  - Tested standalone.
- acc and sat are held as unpacked arrays [NCH]. There is no RAM inference; the read mux is a plain index.

## Test plan
- Reset: assert rst_n=0 mid-cycle, including during a drain. All outputs go to their reset values asynchronously. A following drain returns all zeros with out_sat=0.
- Load then accumulate: NCH=4. Load ch2=100, then accumulate ch2 +23 and +7. Drain returns (ch0,0), (ch1,0), (ch2,130), (ch3,0) on consecutive cycles.
- Saturation: load ch1=2^29-5, then accumulate +10. Drain shows ch1=2^29-1 with out_sat=1. A second drain shows ch1=0 and out_sat=0.
- Backpressure:
  - hold out_ready=0 for 3 cycles on ch0; out_data must stay stable throughout;
  - toggle out_ready 1,0,1,1; exactly 4 words, in order, no duplicates.
- Stall and collision:
  - drain and an accumulate to ch3 (+9, ch3 previously 1) in the same cycle; ch3 drains as 10;
  - in_valid held during DRAIN sees in_ready=0 and no update;
  - the word transfers in the cycle after busy falls.
- Out-of-range and ignored drain: NCH=3 build.
  - in_sel=3: the word is accepted with no state change.
  - A second drain pulse during DRAIN produces no extra words.

Source files
------------

// File: rtl/ac3_pkg.sv
// rtl/ac3_pkg.sv - shared types and width helper for the AC2/AC3 datapath
package ac3_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        LAST  = 2'd2
    } state_t;

    // Accumulator width: index bits of M, both precisions, and headroom for MNO operands.
    function automatic int ac3_width(input int m, input int pa, input int pw, input int mno);
        return $clog2(m) + pa + pw + $clog2(mno);
    endfunction

endpackage

// File: rtl/ac3_sat_add.sv
// rtl/ac3_sat_add.sv - combinational unsigned saturating adder
module ac3_sat_add #(
    parameter int W = 29
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         overflow
);

    logic [W:0] full;

    always_comb begin
        full     = {1'b0, a} + {1'b0, b};
        overflow = full[W];
        sum      = full[W] ? {W{1'b1}} : full[W-1:0];
    end

endmodule

// File: rtl/ac3_acc_bank.sv
// rtl/ac3_acc_bank.sv - NCH-channel load/accumulate bank with clear-on-read drain sequencer
module ac3_acc_bank
    import ac3_pkg::*;
#(
    parameter int M   = 16,
    parameter int Pa  = 8,
    parameter int Pw  = 8,
    parameter int MNO = 288,
    parameter int NCH = 4,
    localparam int W  = ac3_width(M, Pa, Pw, MNO),
    localparam int CW = $clog2(NCH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    input  logic [CW-1:0] in_sel,
    input  logic          in_acc,
    input  logic          drain,
    output logic          busy,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic [CW-1:0] out_ch,
    output logic          out_sat
);

    localparam logic [CW:0]   NCH_L    = (CW+1)'(NCH);
    localparam logic [CW-1:0] LAST_IDX = CW'(NCH - 1);

    logic [W-1:0]  acc     [NCH];
    logic [W-1:0]  acc_nxt [NCH];
    logic          sat     [NCH];
    logic          sat_nxt [NCH];
    state_t        state, state_nxt;
    logic [CW-1:0] rd_ptr, ptr_nxt, ptr_inc;
    logic [CW-1:0] sel_idx;
    logic          sel_ok, xfer, hs;
    logic [W-1:0]  add_sum;
    logic          add_ovf;

    assign sel_ok  = {1'b0, in_sel} < NCH_L;
    assign sel_idx = sel_ok ? in_sel : '0;
    assign xfer    = in_valid & in_ready;
    assign hs      = out_valid & out_ready;
    assign busy    = (state != IDLE);
    assign ptr_inc = rd_ptr + CW'(1);

    ac3_sat_add #(.W(W)) u_add (
        .a        (acc[sel_idx]),
        .b        (in_data),
        .sum      (add_sum),
        .overflow (add_ovf)
    );

    always_comb begin
        acc_nxt   = acc;
        sat_nxt   = sat;
        state_nxt = state;
        ptr_nxt   = rd_ptr;
        // Out-of-range selects are consumed but never written.
        if (xfer && sel_ok) begin
            if (in_acc) begin
                acc_nxt[sel_idx] = add_sum;
                if (add_ovf) sat_nxt[sel_idx] = 1'b1;
            end else begin
                acc_nxt[sel_idx] = in_data;
                sat_nxt[sel_idx] = 1'b0;
            end
        end
        case (state)
            IDLE: begin
                if (drain) begin
                    state_nxt = DRAIN;
                    ptr_nxt   = '0;
                end
            end
            DRAIN: begin
                if (hs) begin
                    acc_nxt[rd_ptr] = '0;
                    sat_nxt[rd_ptr] = 1'b0;
                    ptr_nxt         = ptr_inc;
                    if (ptr_inc == LAST_IDX) state_nxt = LAST;
                end
            end
            LAST: begin
                if (hs) begin
                    acc_nxt[rd_ptr] = '0;
                    sat_nxt[rd_ptr] = 1'b0;
                    ptr_nxt         = '0;
                    state_nxt       = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                ptr_nxt   = '0;
            end
        endcase
    end

    // Output registers load from next-state values so a same-cycle transfer shows in the drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                acc[i] <= '0;
                sat[i] <= 1'b0;
            end
            state     <= IDLE;
            rd_ptr    <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            out_sat   <= 1'b0;
        end else begin
            acc       <= acc_nxt;
            sat       <= sat_nxt;
            state     <= state_nxt;
            rd_ptr    <= ptr_nxt;
            in_ready  <= (state_nxt == IDLE);
            out_valid <= (state_nxt != IDLE);
            out_data  <= (state_nxt != IDLE) ? acc_nxt[ptr_nxt] : '0;
            out_ch    <= (state_nxt != IDLE) ? ptr_nxt : '0;
            out_sat   <= (state_nxt != IDLE) ? sat_nxt[ptr_nxt] : 1'b0;
        end
    end

endmodule

// File: tb/tb_ac3_acc_bank.sv
// tb/tb_ac3_acc_bank.sv - directed self-checking bench for ac3_acc_bank and ac3_sat_add
module tb_ac3_acc_bank;

    logic        clk;
    logic        rst_n;

    logic        a_in_valid, a_in_ready, a_in_acc, a_drain, a_busy;
    logic        a_out_valid, a_out_ready, a_out_sat;
    logic [28:0] a_in_data, a_out_data;
    logic [1:0]  a_in_sel, a_out_ch;

    logic        b_in_valid, b_in_ready, b_in_acc, b_drain, b_busy;
    logic        b_out_valid, b_out_ready, b_out_sat;
    logic [28:0] b_in_data, b_out_data;
    logic [1:0]  b_in_sel, b_out_ch;

    logic [28:0] s_a, s_b, s_sum;
    logic        s_ovf;

    int          checks = 0;
    int          errors = 0;
    logic [28:0] wd [8];
    logic        ws [8];
    logic [1:0]  wc [8];
    int          n, cyc;
    logic [28:0] or_data;
    logic        or_sat;

    ac3_acc_bank #(.NCH(4)) u_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .in_sel(a_in_sel), .in_acc(a_in_acc), .drain(a_drain), .busy(a_busy),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .out_ch(a_out_ch), .out_sat(a_out_sat)
    );

    ac3_acc_bank #(.NCH(3)) u_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .in_sel(b_in_sel), .in_acc(b_in_acc), .drain(b_drain), .busy(b_busy),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_ch(b_out_ch), .out_sat(b_out_sat)
    );

    ac3_sat_add #(.W(29)) u_s (.a(s_a), .b(s_b), .sum(s_sum), .overflow(s_ovf));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put_a(input logic [1:0] sel, input logic acc, input logic [28:0] d);
        a_in_valid = 1'b1; a_in_sel = sel; a_in_acc = acc; a_in_data = d;
        tick();
        a_in_valid = 1'b0;
    endtask

    task automatic pulse_a();
        a_drain = 1'b1;
        tick();
        a_drain = 1'b0;
    endtask

    // Words are recorded when out_valid & out_ready hold just before the clock edge.
    task automatic collect_a(input logic [3:0] pat, output int cnt, output int cy);
        cnt = 0;
        cy  = 0;
        while (a_busy && cy < 30) begin
            a_out_ready = (cy < 4) ? pat[cy] : 1'b1;
            if (a_out_valid && a_out_ready && cnt < 8) begin
                wd[cnt] = a_out_data; ws[cnt] = a_out_sat; wc[cnt] = a_out_ch;
                cnt++;
            end
            tick();
            cy++;
        end
        a_out_ready = 1'b1;
        chk("a_busy_end", {31'd0, a_busy}, 32'd0);
    endtask

    task automatic collect_b(output int cnt);
        int cy;
        cnt = 0;
        cy  = 0;
        b_out_ready = 1'b1;
        while (b_busy && cy < 30) begin
            b_drain = (cy == 1);
            if (b_out_valid && cnt < 8) begin
                wd[cnt] = b_out_data; ws[cnt] = b_out_sat; wc[cnt] = b_out_ch;
                cnt++;
            end
            tick();
            cy++;
        end
        b_drain = 1'b0;
        chk("b_busy_end", {31'd0, b_busy}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b1;
        a_in_valid = 0; a_in_sel = 0; a_in_acc = 0; a_in_data = 0; a_drain = 0; a_out_ready = 1;
        b_in_valid = 0; b_in_sel = 0; b_in_acc = 0; b_in_data = 0; b_drain = 0; b_out_ready = 1;
        s_a = 0; s_b = 0;

        // Standalone saturating adder
        s_a = 29'd5; s_b = 29'd7; #1;
        chk("add_sum_small", {3'd0, s_sum}, 32'd12);
        chk("add_ovf_small", {31'd0, s_ovf}, 32'd0);
        s_a = 29'h1FFFFFFF; s_b = 29'd1; #1;
        chk("add_sum_carry", {3'd0, s_sum}, 32'h1FFFFFFF);
        chk("add_ovf_carry", {31'd0, s_ovf}, 32'd1);
        s_a = 29'h1FFFFFF0; s_b = 29'hF; #1;
        chk("add_sum_edge", {3'd0, s_sum}, 32'h1FFFFFFF);
        chk("add_ovf_edge", {31'd0, s_ovf}, 32'd0);

        // Asynchronous reset
        rst_n = 1'b0;
        #1;
        chk("rst_in_ready", {31'd0, a_in_ready}, 32'd1);
        chk("rst_busy", {31'd0, a_busy}, 32'd0);
        chk("rst_out_valid", {31'd0, a_out_valid}, 32'd0);
        chk("rst_out_data", {3'd0, a_out_data}, 32'd0);
        chk("rst_out_ch", {30'd0, a_out_ch}, 32'd0);
        chk("rst_out_sat", {31'd0, a_out_sat}, 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Load then accumulate
        put_a(2'd2, 1'b0, 29'd100);
        put_a(2'd2, 1'b1, 29'd23);
        put_a(2'd2, 1'b1, 29'd7);
        pulse_a();
        chk("drn_busy", {31'd0, a_busy}, 32'd1);
        chk("drn_in_ready", {31'd0, a_in_ready}, 32'd0);
        collect_a(4'b1111, n, cyc);
        chk("la_count", n, 32'd4);
        chk("la_cycles", cyc, 32'd4);
        chk("la_ch0", {3'd0, wd[0]}, 32'd0);
        chk("la_ch1", {3'd0, wd[1]}, 32'd0);
        chk("la_ch2", {3'd0, wd[2]}, 32'd130);
        chk("la_ch3", {3'd0, wd[3]}, 32'd0);
        chk("la_idx2", {30'd0, wc[2]}, 32'd2);
        chk("la_in_ready_end", {31'd0, a_in_ready}, 32'd1);
        chk("la_out_valid_end", {31'd0, a_out_valid}, 32'd0);

        // Saturation and clear-on-read
        put_a(2'd1, 1'b0, 29'h1FFFFFFB);
        put_a(2'd1, 1'b1, 29'd10);
        pulse_a();
        collect_a(4'b1111, n, cyc);
        chk("sat_data", {3'd0, wd[1]}, 32'h1FFFFFFF);
        chk("sat_flag", {31'd0, ws[1]}, 32'd1);
        chk("sat_other_flag", {31'd0, ws[0]}, 32'd0);
        pulse_a();
        collect_a(4'b1111, n, cyc);
        chk("sat2_data", {3'd0, wd[1]}, 32'd0);
        chk("sat2_flag", {31'd0, ws[1]}, 32'd0);

        // Backpressure
        put_a(2'd0, 1'b0, 29'd55);
        a_out_ready = 1'b0;
        pulse_a();
        for (int i = 0; i < 3; i++) begin
            chk("bp_hold_data", {3'd0, a_out_data}, 32'd55);
            chk("bp_hold_ch", {30'd0, a_out_ch}, 32'd0);
            tick();
        end
        collect_a(4'b1101, n, cyc);
        chk("bp_count", n, 32'd4);
        chk("bp_first", {3'd0, wd[0]}, 32'd55);
        for (int i = 0; i < 4; i++) chk("bp_order", {30'd0, wc[i]}, i);

        // Collision of drain with an accumulate, then a stalled word
        put_a(2'd3, 1'b0, 29'd1);
        a_in_valid = 1'b1; a_in_sel = 2'd3; a_in_acc = 1'b1; a_in_data = 29'd9; a_drain = 1'b1;
        tick();
        a_drain = 1'b0;
        a_in_sel = 2'd0; a_in_acc = 1'b0; a_in_data = 29'd77;
        chk("col_in_ready", {31'd0, a_in_ready}, 32'd0);
        collect_a(4'b1111, n, cyc);
        chk("col_ch3", {3'd0, wd[3]}, 32'd10);
        chk("col_ch0_stalled", {3'd0, wd[0]}, 32'd0);
        chk("col_ready_back", {31'd0, a_in_ready}, 32'd1);
        tick();
        a_in_valid = 1'b0;
        pulse_a();
        collect_a(4'b1111, n, cyc);
        chk("col_late_word", {3'd0, wd[0]}, 32'd77);

        // Reset in the middle of a drain
        put_a(2'd1, 1'b0, 29'd5);
        put_a(2'd2, 1'b0, 29'h1FFFFFFF);
        put_a(2'd2, 1'b1, 29'd1);
        a_out_ready = 1'b1;
        pulse_a();
        tick();
        a_out_ready = 1'b0;
        chk("mid_data", {3'd0, a_out_data}, 32'd5);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, a_out_valid}, 32'd0);
        chk("mid_rst_busy", {31'd0, a_busy}, 32'd0);
        chk("mid_rst_ready", {31'd0, a_in_ready}, 32'd1);
        chk("mid_rst_data", {3'd0, a_out_data}, 32'd0);
        chk("mid_rst_ch", {30'd0, a_out_ch}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        pulse_a();
        collect_a(4'b1111, n, cyc);
        or_data = '0; or_sat = 1'b0;
        for (int i = 0; i < 4; i++) begin
            or_data = or_data | wd[i];
            or_sat  = or_sat | ws[i];
        end
        chk("post_rst_count", n, 32'd4);
        chk("post_rst_data", {3'd0, or_data}, 32'd0);
        chk("post_rst_sat", {31'd0, or_sat}, 32'd0);

        // NCH=3: out-of-range select and ignored drain
        b_in_valid = 1'b1; b_in_sel = 2'd2; b_in_acc = 1'b0; b_in_data = 29'd40;
        tick();
        b_in_sel = 2'd3; b_in_data = 29'd123;
        chk("oor_ready", {31'd0, b_in_ready}, 32'd1);
        tick();
        b_in_sel = 2'd3; b_in_acc = 1'b1; b_in_data = 29'd50;
        tick();
        b_in_valid = 1'b0;
        b_drain = 1'b1;
        tick();
        b_drain = 1'b0;
        collect_b(n);
        chk("oor_count", n, 32'd3);
        chk("oor_ch0", {3'd0, wd[0]}, 32'd0);
        chk("oor_ch1", {3'd0, wd[1]}, 32'd0);
        chk("oor_ch2", {3'd0, wd[2]}, 32'd40);
        chk("oor_last_idx", {30'd0, wc[2]}, 32'd2);
        tick(); tick();
        chk("ign_valid", {31'd0, b_out_valid}, 32'd0);
        chk("ign_busy", {31'd0, b_busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
